// File: rtl/ws2812_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_ram_reader
// Description : Reads per-LED colour words from an on-chip RAM port, reorders
//               them to GRB and serialises them as a WS2812 bitstream, with a
//               low latch period after every frame. Frames repeat while
//               enable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_ram_reader #(
    parameter int NUM_LEDS     = 60,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 1,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int T_BIT        = 63,
    parameter int T_LATCH      = 3000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    output logic [12:0] ram_mm_address,
    output logic        ram_mm_chipselect,
    output logic        ram_mm_clken,
    output logic        ram_mm_write,
    input  logic [31:0] ram_mm_readdata,
    output logic [31:0] ram_mm_writedata,
    output logic [3:0]  ram_mm_byteenable,
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done
);

    // Counter widths
    localparam int CW = $clog2(T_BIT);
    localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
    localparam int RW = $clog2(READ_LATENCY + 1);

    localparam logic [CW-1:0] C_BIT_LAST   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] C_T0H        = CW'(T0H);
    localparam logic [CW-1:0] C_T1H        = CW'(T1H);
    localparam logic [LW-1:0] C_LATCH_LAST = LW'(T_LATCH - 1);
    localparam logic [LW-1:0] C_LATCH_PEN  = LW'(T_LATCH - 2);
    localparam logic [RW-1:0] C_RL         = RW'(READ_LATENCY);
    localparam logic [12:0]   C_BASE       = 13'(BASE_ADDR);
    localparam logic [12:0]   C_LAST_IDX   = 13'(NUM_LEDS - 1);
    // Line level on counter 0 of a bit, for a '0' and a '1' bit
    localparam logic          C_HI0_0      = (T0H > 0);
    localparam logic          C_HI0_1      = (T1H > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t          state_q;
    logic [12:0]     addr_q;
    logic            cs_q;
    logic            dout_q;
    logic            busy_q;
    logic            fd_q;
    logic [12:0]     idx_q;
    logic [4:0]      bit_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   lat_q;
    logic            pf_pend_q;
    logic [LW-1:0]   lcnt_q;
    logic [23:0]     shift_q;
    logic [23:0]     next_q;

    logic [23:0]     w_rd_grb;
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_thr;
    logic            unused_rd_hi;

    // RAM word is {pad, R, G, B}; the LED wants G, R, B MSB first
    assign w_rd_grb     = {ram_mm_readdata[15:8], ram_mm_readdata[23:16], ram_mm_readdata[7:0]};
    assign w_cnt_inc    = cnt_q + CW'(1);
    assign w_thr        = shift_q[23] ? C_T1H : C_T0H;
    assign unused_rd_hi = ^ram_mm_readdata[31:24];

    // Frame sequencer: fetch, prefetch, bit timing and latch in one FSM
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
            idx_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            pf_pend_q <= 1'b0;
            lcnt_q    <= '0;
            shift_q   <= '0;
            next_q    <= '0;
        end else begin
            cs_q <= 1'b0;
            fd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= C_BASE;
                        idx_q   <= '0;
                    end
                end

                S_FETCH: begin
                    // Strobe was raised on entry; count latency from here
                    state_q <= S_WAIT;
                    lat_q   <= RW'(1);
                end

                S_WAIT: begin
                    if (lat_q == C_RL) begin
                        shift_q <= w_rd_grb;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        dout_q  <= w_rd_grb[23] ? C_HI0_1 : C_HI0_0;
                        state_q <= S_SHIFT;
                    end else begin
                        lat_q <= lat_q + RW'(1);
                    end
                end

                S_SHIFT: begin
                    // Capture the next LED's word once its read has landed
                    if (pf_pend_q) begin
                        if (lat_q == C_RL) begin
                            next_q    <= w_rd_grb;
                            pf_pend_q <= 1'b0;
                        end else begin
                            lat_q <= lat_q + RW'(1);
                        end
                    end

                    if (cnt_q == C_BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 5'd23) begin
                            if (idx_q == C_LAST_IDX) begin
                                state_q <= S_LATCH;
                                dout_q  <= 1'b0;
                                lcnt_q  <= '0;
                                if (T_LATCH == 1) begin
                                    fd_q <= 1'b1;
                                end
                            end else begin
                                idx_q   <= idx_q + 13'd1;
                                bit_q   <= '0;
                                shift_q <= next_q;
                                dout_q  <= next_q[23] ? C_HI0_1 : C_HI0_0;
                            end
                        end else begin
                            bit_q   <= bit_q + 5'd1;
                            shift_q <= {shift_q[22:0], 1'b0};
                            dout_q  <= shift_q[22] ? C_HI0_1 : C_HI0_0;
                            // Strobe lands on counter 0 of bit 23
                            if (bit_q == 5'd22 && idx_q != C_LAST_IDX) begin
                                cs_q      <= 1'b1;
                                addr_q    <= C_BASE + idx_q + 13'd1;
                                pf_pend_q <= 1'b1;
                                lat_q     <= '0;
                            end
                        end
                    end else begin
                        cnt_q  <= w_cnt_inc;
                        dout_q <= (w_cnt_inc < w_thr);
                    end
                end

                S_LATCH: begin
                    if (lcnt_q == C_LATCH_LAST) begin
                        idx_q <= '0;
                        if (enable) begin
                            state_q <= S_FETCH;
                            cs_q    <= 1'b1;
                            addr_q  <= C_BASE;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        lcnt_q <= lcnt_q + LW'(1);
                        if (lcnt_q == C_LATCH_PEN) begin
                            fd_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_mm_address    = addr_q;
    assign ram_mm_chipselect = cs_q;
    assign ram_mm_clken      = 1'b1;
    assign ram_mm_write      = 1'b0;
    assign ram_mm_writedata  = 32'h0000_0000;
    assign ram_mm_byteenable = 4'hF;
    assign led_dout          = dout_q;
    assign busy              = busy_q;
    assign frame_done        = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_ram_reader
// Description : Directed bench for ws2812_ram_reader with two LEDs; one DUT at
//               read latency 1 and one at read latency 2 share the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_ram_reader;

    localparam int NREC = 12100;
    // GRB stream for RAM[0]=00FF0000 and RAM[1]=000000A5
    localparam logic [47:0] C_STREAM = 48'h00FF00_0000A5;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic [12:0] addr1, addr2;
    logic        cs1, cs2, clken1, clken2, wr1, wr2;
    logic [31:0] rd1, rd2, wd1, wd2;
    logic [3:0]  be1, be2;
    logic        led1, led2, busy1, busy2, fd1, fd2;

    ws2812_ram_reader #(.NUM_LEDS(2), .READ_LATENCY(1)) dut1 (
        .clk_clk(clk), .reset_reset(rst), .enable(en),
        .ram_mm_address(addr1), .ram_mm_chipselect(cs1), .ram_mm_clken(clken1),
        .ram_mm_write(wr1), .ram_mm_readdata(rd1), .ram_mm_writedata(wd1),
        .ram_mm_byteenable(be1), .led_dout(led1), .busy(busy1), .frame_done(fd1)
    );

    ws2812_ram_reader #(.NUM_LEDS(2), .READ_LATENCY(2)) dut2 (
        .clk_clk(clk), .reset_reset(rst), .enable(en),
        .ram_mm_address(addr2), .ram_mm_chipselect(cs2), .ram_mm_clken(clken2),
        .ram_mm_write(wr2), .ram_mm_readdata(rd2), .ram_mm_writedata(wd2),
        .ram_mm_byteenable(be2), .led_dout(led2), .busy(busy2), .frame_done(fd2)
    );

    function automatic logic [31:0] ram_rd(logic [12:0] a);
        if (a == 13'd0) return 32'h00FF_0000;
        if (a == 13'd1) return 32'h0000_00A5;
        return 32'hDEAD_BEEF;
    endfunction

    // RAM responders: data valid for exactly one cycle, junk otherwise
    logic        p_cs;
    logic [12:0] p_a;
    always @(posedge clk) begin
        rd1  <= cs1 ? ram_rd(addr1) : 32'h3C5A_C35A;
        p_cs <= cs2;
        p_a  <= addr2;
        rd2  <= p_cs ? ram_rd(p_a) : 32'h3C5A_C35A;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    bit          r_led1 [0:NREC-1];
    bit          r_led2 [0:NREC-1];
    bit          r_cs1  [0:NREC-1];
    bit          r_fd1  [0:NREC-1];
    bit          r_fd2  [0:NREC-1];
    bit          r_busy1[0:NREC-1];
    logic [12:0] r_addr1[0:NREC-1];
    int          b2b_cnt;
    int          wr_cnt;

    // Sample n cycles at negedges; index j is the j-th cycle after start edge
    task automatic record(input int n, input int drop_at);
        logic prev1, prev2;
        prev1 = 1'b0;
        prev2 = 1'b0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            r_led1[j]  = led1;
            r_led2[j]  = led2;
            r_cs1[j]   = cs1;
            r_fd1[j]   = fd1;
            r_fd2[j]   = fd2;
            r_busy1[j] = busy1;
            r_addr1[j] = addr1;
            if ((cs1 && prev1) || (cs2 && prev2)) b2b_cnt++;
            prev1 = cs1;
            prev2 = cs2;
            if (wr1 || wr2) wr_cnt++;
            if (j == drop_at) en = 1'b0;
        end
    endtask

    // Expected line level r cycles after the enable-sampling edge
    function automatic bit exp_led(int r);
        logic [47:0] s;
        int b, c;
        s = C_STREAM;
        if (r < 3 || r >= 3 + 48 * 63) return 1'b0;
        b = (r - 3) / 63;
        c = (r - 3) % 63;
        return (c < (s[47 - b] ? 40 : 20));
    endfunction

    task automatic wave(input string tag, input bit which, input int j0, input int j1, input int off);
        int first_bad;
        bit got;
        first_bad = -1;
        for (int j = j0; j <= j1; j++) begin
            got = which ? r_led2[j] : r_led1[j];
            if (got != exp_led(j - off) && first_bad < 0) first_bad = j;
        end
        chk(tag, first_bad, -1);
    endtask

    function automatic int run_len(int j);
        int n;
        n = 0;
        while (j + n < NREC && r_led1[j + n]) n++;
        return n;
    endfunction

    task automatic fd_chk(input string tag, input bit which, input int j0, input int j1, input int exp_pos);
        int cnt, pos;
        cnt = 0;
        pos = -1;
        for (int j = j0; j <= j1; j++) begin
            if (which ? r_fd2[j] : r_fd1[j]) begin
                cnt++;
                if (pos < 0) pos = j;
            end
        end
        chk({tag, "_cnt"}, cnt, 1);
        chk({tag, "_pos"}, pos, exp_pos);
    endtask

    task automatic cs_chk(input string tag, input int j0, input int j1, input int n,
                          input int p0, input int p1, input int p2, input int p3);
        int pos[$];
        int adr[$];
        int ep[4];
        ep = '{p0, p1, p2, p3};
        for (int j = j0; j <= j1; j++) begin
            if (r_cs1[j]) begin
                pos.push_back(j);
                adr.push_back(int'(r_addr1[j]));
            end
        end
        chk({tag, "_n"}, pos.size(), n);
        for (int i = 0; i < n && i < pos.size(); i++) begin
            chk($sformatf("%s_pos%0d", tag, i), pos[i], ep[i]);
            chk($sformatf("%s_adr%0d", tag, i), adr[i], i % 2);
        end
    endtask

    initial begin
        b2b_cnt = 0;
        wr_cnt  = 0;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_led",  led1,  0);
            chk("rst_cs",   cs1,   0);
            chk("rst_busy", busy1, 0);
            chk("rst_fd",   fd1,   0);
        end
        chk("clken", clken1, 1);
        chk("byteen", be1, 15);
        chk("wdata", wd1, 0);

        // Two back-to-back frames with enable held high
        rst = 1'b0;
        record(12060, 0);
        chk("busy_t1", r_busy1[1], 1);
        chk("led_t2",  r_led1[2],  0);
        chk("led_t3",  r_led1[3],  1);
        chk("w_led0_g7", run_len(3),           20);
        chk("w_led0_r7", run_len(3 + 8 * 63),  40);
        chk("w_led0_b7", run_len(3 + 16 * 63), 20);
        chk("w_led1_b7", run_len(3 + 40 * 63), 40);
        chk("w_led1_b6", run_len(3 + 41 * 63), 20);
        chk("latch_low", run_len(3027), 0);
        wave("wave_f1", 1'b0, 1, 6026, 0);
        wave("wave_f2", 1'b0, 6027, 12052, 6026);
        wave("wave_rl2", 1'b1, 1, 6027, 1);
        fd_chk("fd_f1", 1'b0, 1, 6030, 6026);
        fd_chk("fd_rl2", 1'b1, 1, 6030, 6027);
        cs_chk("cs2f", 1, 12052, 4, 1, 1452, 6027, 7478);
        chk("busy_f2", r_busy1[6027], 1);

        // Third frame: reset in the high phase of LED1 bit 10
        repeat (14205 - 12060) @(negedge clk);
        chk("pre_rst_led", led1, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_led",  led1,  0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_cs",   cs1,   0);
        rst = 1'b0;
        // Fresh frame; enable dropped during LED0 bit 5
        record(6400, 3 + 5 * 63 + 10);
        wave("wave_rst", 1'b0, 1, 6026, 0);
        cs_chk("csdrop", 1, 6400, 2, 1, 1452, 0, 0);
        fd_chk("fd_drop", 1'b0, 1, 6400, 6026);
        chk("busy_last_latch", r_busy1[6026], 1);
        chk("busy_fall",       r_busy1[6027], 0);
        chk("busy_idle",       r_busy1[6400], 0);
        chk("cs_b2b", b2b_cnt, 0);
        chk("write_seen", wr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_ram_reader.md
Name: ws2812_ram_reader

Overview:
Fabric-side master for the on-chip RAM port (ram_mm_*) that the HPS fills with per-LED colour words. Each frame it reads NUM_LEDS consecutive 32-bit words, reorders them to GRB, and drives them as a WS2812 serial bitstream on a single pin. After the last LED it holds the line low for the latch time. It runs back-to-back frames while enabled.

Parameters:
NUM_LEDS, 60, LEDs per frame; legal range 1 to 8192-BASE_ADDR.
BASE_ADDR, 0, word address of LED 0 in the RAM.
READ_LATENCY, 1, cycles from chipselect to valid readdata; legal range 1 to T_BIT-2.
T0H, 20, high cycles for a '0' bit (0.4 us at 50 MHz).
T1H, 40, high cycles for a '1' bit (0.8 us).
T_BIT, 63, total cycles per bit; must be greater than T1H.
T_LATCH, 3000, low cycles after the last bit (60 us).

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
enable  in  1  level; frames repeat while high
ram_mm_address  out  13  word address
ram_mm_chipselect  out  1  one-cycle read strobe
ram_mm_clken  out  1  constant 1
ram_mm_write  out  1  constant 0
ram_mm_readdata  in  32  word {8'h00, R, G, B}
ram_mm_writedata  out  32  constant 0
ram_mm_byteenable  out  4  constant 4'hF
led_dout  out  1  WS2812 data line
busy  out  1  high from frame start to end of latch
frame_done  out  1  one-cycle pulse at end of latch

Behaviour:
- Clock and reset: clk_clk is the only clock; reset_reset is synchronous and active-high.
- Reset values, all registered: address 0, chipselect 0, led_dout 0, busy 0, frame_done 0. Internal state is IDLE, LED index 0, bit index 0.
- States: IDLE, FETCH, WAIT, SHIFT, LATCH.
- IDLE: if enable is sampled high at cycle t, the block enters FETCH and busy goes high at t+1.
- FETCH: for exactly one cycle, chipselect=1 and address=BASE_ADDR+idx. Then go to WAIT.
- WAIT: count READ_LATENCY cycles. On the cycle readdata is valid, load shift_reg = {rd[15:8], rd[23:16], rd[7:0]} (G,R,B, MSB first). Then go to SHIFT.
- First LED start: the first bit's high phase begins at cycle t+2+READ_LATENCY.
- SHIFT, per bit: a counter runs 0..T_BIT-1. led_dout=1 while counter < (bit ? T1H : T0H), otherwise 0.
- After counter T_BIT-1: shift left and increment the bit index. Bits are back-to-back, with no idle cycles between them.
- Prefetch: on counter==0 of bit 23 of LED idx, when idx<NUM_LEDS-1, issue a one-cycle read of BASE_ADDR+idx+1.
- Prefetched data is captured into next_reg READ_LATENCY cycles later.
- At the end of bit 23, shift_reg loads from next_reg and idx increments. There is no gap between LEDs.
- After bit 23 of LED NUM_LEDS-1: enter LATCH with led_dout=0.
- LATCH: hold for T_LATCH cycles. On the last LATCH cycle, frame_done=1 for one cycle, idx returns to 0, and the block re-evaluates enable.
  - enable high: enter FETCH; busy stays high.
  - enable low: enter IDLE; busy falls on the next cycle.
- enable falling mid-frame is ignored. The frame, including LATCH, completes.
- Reset asserted in any state: on the next edge, every output returns to its reset value. Any in-flight read is abandoned and its readdata ignored. The next frame starts at BASE_ADDR.
- Bus rules:
  - chipselect is never high for two consecutive cycles.
  - ram_mm_write is never 1.
  - Addresses are 13-bit; BASE_ADDR+NUM_LEDS-1 must not exceed 8191, so no wrap occurs.
- Frame length: 24*NUM_LEDS*T_BIT cycles of bitstream plus T_LATCH.

Test Plan:
- Reset: hold reset_reset 3 cycles with enable=1 -> led_dout=0, chipselect=0, busy=0, frame_done=0, clken=1, byteenable=4'hF throughout.
- Default timing, NUM_LEDS=2, RAM[0]=0x00FF0000, RAM[1]=0x000000A5, enable=1 at cycle t:
  - chipselect at t+1 with address 0; first rising edge of led_dout at t+3.
  - LED0: 8 highs of 20 cycles (G=00), then 8 highs of 40 cycles (R=FF), then 8 highs of 20 cycles (B=00).
  - LED1: G=00, R=00, then B=A5 -> high widths 40,20,40,20,20,40,20,40.
  - Every bit period is exactly 63 cycles.
  - Then 3000 low cycles, and frame_done pulses once at cycle t+3+3024+2999.
- Address trace over two frames -> reads at 0,1,0,1; each chipselect lasts one cycle; second-frame read of 1 is issued during bit 23 of LED0; write always 0.
- READ_LATENCY=2 with the same RAM contents -> identical led_dout waveform shifted by exactly +1 cycle; no extra gap between LEDs.
- Drop enable during LED0 bit 5 -> full frame and latch complete, frame_done pulses, busy falls the following cycle, and no further chipselect occurs.
- Assert reset_reset during LED1 bit 10, then release with enable=1 -> next cycle led_dout=0, busy=0; restart issues a read at address BASE_ADDR, and the waveform matches a fresh frame.
